// File: rtl/icache_pkg.sv
// Shared cache geometry, address layout and controller state encodings.
// The D-cache controller is expected to import the same package.
package icache_pkg;

  localparam int ICACHE_LINES = 32;
  localparam int ICACHE_WORDS = 8;
  localparam int ICACHE_TAG_W = 7;
  localparam int ICACHE_IDX_W = 5;
  localparam int ICACHE_OFF_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Tag, valid and data storage for the direct-mapped I-cache.
// Combinational read by (idx, off); synchronous single-word write plus set-valid strobe.
module icache_line_array
  import icache_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ICACHE_IDX_W-1:0] i_rd_idx,
  input  logic [ICACHE_OFF_W-1:0] i_rd_off,
  output logic [15:0]             o_rd_data,
  output logic [ICACHE_TAG_W-1:0] o_rd_tag,
  output logic                    o_rd_valid,
  input  logic                    i_wr_en,
  input  logic [ICACHE_IDX_W-1:0] i_wr_idx,
  input  logic [ICACHE_OFF_W-1:0] i_wr_off,
  input  logic [15:0]             i_wr_data,
  input  logic                    i_set_valid,
  input  logic [ICACHE_TAG_W-1:0] i_set_tag
);

  logic [15:0]             r_data  [ICACHE_LINES][ICACHE_WORDS];
  logic [ICACHE_TAG_W-1:0] r_tag   [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] r_valid;

  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

  // Only the valid bits are reset; tag and data contents are don't-care until valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_set_valid) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    end
    if (i_set_valid) begin
      r_tag[i_wr_idx] <= i_set_tag;
    end
  end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped I-cache front end: same-cycle hit path, blocking whole-line miss fill.
//   state   | meaning
//   ST_IDLE | lookup fetch_addr each cycle; a miss latches tag/idx and starts a fill
//   ST_FILL | issue 8 word reads, write each return, mark line valid on the 8th
module icache_fetch_ctrl
  import icache_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_req,
  input  logic [15:0] i_fetch_addr,
  output logic [15:0] o_inst_out,
  output logic        o_inst_valid,
  output logic        o_stall,
  output logic        o_mem_rd_req,
  output logic [15:0] o_mem_addr,
  input  logic [15:0] i_mem_rd_data,
  input  logic        i_mem_rd_valid,
  output logic [15:0] o_hit_cnt,
  output logic [15:0] o_miss_cnt
);

  logic [0:0]              r_state;
  logic [3:0]              r_issue_cnt;
  logic [ICACHE_OFF_W-1:0] r_recv_cnt;
  logic [ICACHE_TAG_W-1:0] r_miss_tag;
  logic [ICACHE_IDX_W-1:0] r_miss_idx;
  logic [15:0]             r_hit_cnt;
  logic [15:0]             r_miss_cnt;

  logic [ICACHE_TAG_W-1:0] w_tag;
  logic [ICACHE_IDX_W-1:0] w_idx;
  logic [ICACHE_OFF_W-1:0] w_off;
  logic                    w_unused_byte_bit;
  logic [15:0]             w_line_data;
  logic [ICACHE_TAG_W-1:0] w_line_tag;
  logic                    w_line_valid;
  logic                    w_idle;
  logic                    w_hit;
  logic                    w_miss;
  logic                    w_fill_wr;
  logic                    w_fill_done;

  assign w_tag             = i_fetch_addr[15:9];
  assign w_idx             = i_fetch_addr[8:4];
  assign w_off             = i_fetch_addr[3:1];
  assign w_unused_byte_bit = i_fetch_addr[0];

  icache_line_array u_lines (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_idx    (w_idx),
    .i_rd_off    (w_off),
    .o_rd_data   (w_line_data),
    .o_rd_tag    (w_line_tag),
    .o_rd_valid  (w_line_valid),
    .i_wr_en     (w_fill_wr),
    .i_wr_idx    (r_miss_idx),
    .i_wr_off    (r_recv_cnt),
    .i_wr_data   (i_mem_rd_data),
    .i_set_valid (w_fill_done),
    .i_set_tag   (r_miss_tag)
  );

  assign w_idle      = (r_state == ST_IDLE);
  assign w_hit       = w_idle & w_line_valid & (w_line_tag == w_tag);
  assign w_miss      = w_idle & i_fetch_req & ~w_hit;
  assign w_fill_wr   = ~w_idle & i_mem_rd_valid;
  assign w_fill_done = w_fill_wr & (r_recv_cnt == 3'd7);

  assign o_inst_out   = w_line_data;
  assign o_inst_valid = i_fetch_req & w_hit;
  assign o_stall      = (i_fetch_req & ~o_inst_valid) | ~w_idle;
  // issue_cnt bit 3 marks all eight requests sent
  assign o_mem_rd_req = ~w_idle & ~r_issue_cnt[3];
  assign o_mem_addr   = {r_miss_tag, r_miss_idx, r_issue_cnt[2:0], 1'b0};
  assign o_hit_cnt    = r_hit_cnt;
  assign o_miss_cnt   = r_miss_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_miss_tag  <= '0;
      r_miss_idx  <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (o_inst_valid) begin
        r_hit_cnt <= sat_inc16(r_hit_cnt);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            r_state     <= ST_FILL;
            r_miss_tag  <= w_tag;
            r_miss_idx  <= w_idx;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_miss_cnt  <= sat_inc16(r_miss_cnt);
          end
        end
        default: begin
          if (o_mem_rd_req) begin
            r_issue_cnt <= r_issue_cnt + 4'd1;
          end
          if (i_mem_rd_valid) begin
            r_recv_cnt <= r_recv_cnt + 3'd1;
            if (r_recv_cnt == 3'd7) begin
              r_state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Bench for icache_fetch_ctrl: 4-cycle pipelined memory model, data = addr ^ 16'hA5A5,
// expected instructions queued at fetch time and compared when inst_valid appears.
module tb_icache_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] inst_out;
  logic        inst_valid;
  logic        stall;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic        noise;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];
  logic [15:0] req_log[$];

  always #5 clk = ~clk;

  icache_fetch_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_fetch_req    (fetch_req),
    .i_fetch_addr   (fetch_addr),
    .o_inst_out     (inst_out),
    .o_inst_valid   (inst_valid),
    .o_stall        (stall),
    .o_mem_rd_req   (mem_rd_req),
    .o_mem_addr     (mem_addr),
    .i_mem_rd_data  (mem_rd_data),
    .i_mem_rd_valid (mem_rd_valid),
    .o_hit_cnt      (hit_cnt),
    .o_miss_cnt     (miss_cnt)
  );

  // Memory: request sampled at the end of cycle t is returned during cycle t+4.
  logic [3:0]  m_vld;
  logic [15:0] m_dat [0:3];
  always @(posedge clk) begin
    if (!rst_n) begin
      m_vld <= '0;
    end else begin
      m_vld    <= {m_vld[2:0], mem_rd_req};
      m_dat[0] <= mem_addr ^ 16'hA5A5;
      for (int i = 1; i < 4; i++) m_dat[i] <= m_dat[i-1];
      if (mem_rd_req) req_log.push_back(mem_addr);
    end
  end
  assign mem_rd_valid = m_vld[3] | noise;
  assign mem_rd_data  = noise ? 16'hDEAD : m_dat[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the cycle the instruction was served.
  task automatic fetch(input string tag, input logic [15:0] a, input int exp_stall,
                       input int redir_at = 0, input logic [15:0] redir_a = 16'h0000);
    int n;
    bit got;
    logic [15:0] fin;
    fin = (redir_at > 0) ? redir_a : a;
    sb_q.push_back({fin[15:1], 1'b0} ^ 16'hA5A5);
    fetch_req  = 1'b1;
    fetch_addr = a;
    n   = 0;
    got = 1'b0;
    for (int c = 1; c <= 200 && !got; c++) begin
      if (c == redir_at) fetch_addr = redir_a;
      @(negedge clk);
      if (inst_valid) begin
        got = 1'b1;
        chk({tag, " data"}, inst_out, sb_q.pop_front());
        chk({tag, " stall_cycles"}, n, exp_stall);
        chk({tag, " stall_at_hit"}, stall, 1'b0);
      end else if (stall) begin
        n++;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      chk({tag, " timeout"}, got, 1'b1);
      sb_q.delete();
    end
    fetch_req = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input int exp_hit, input int exp_miss);
    chk({tag, " hit_cnt"}, hit_cnt, exp_hit);
    chk({tag, " miss_cnt"}, miss_cnt, exp_miss);
  endtask

  initial begin
    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 16'h0000;
    noise      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst stall", stall, 1'b0);
    chk("rst inst_valid", inst_valid, 1'b0);
    chk("rst mem_rd_req", mem_rd_req, 1'b0);
    chk_cnt("rst", 0, 0);
    fetch_req  = 1'b1;
    fetch_addr = 16'h0040;
    #1;
    chk("rst stall=req", stall, 1'b1);
    chk("rst no hit", inst_valid, 1'b0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    fetch_req = 1'b0;
    req_log.delete();

    // 1 cold miss
    fetch("cold 0040", 16'h0040, 13);
    chk("cold req count", req_log.size(), 8);
    for (int i = 0; i < 8 && i < req_log.size(); i++)
      chk($sformatf("cold mem_addr%0d", i), req_log[i], 16'h0040 + 16'(2 * i));
    chk_cnt("cold", 1, 1);

    // 2 back-to-back hits in the same line
    req_log.delete();
    fetch("hit 0042", 16'h0042, 0);
    chk_cnt("hit 0042", 2, 1);
    fetch("hit 004E", 16'h004E, 0);
    chk_cnt("hit 004E", 3, 1);
    chk("hit no mem req", req_log.size(), 0);

    // 3 conflict on index 4
    fetch("conflict 0240", 16'h0240, 13);
    fetch("refetch 0040", 16'h0040, 13);
    chk_cnt("conflict", 5, 3);

    // 4 redirect mid-fill; 0x0300 shares index 0x10 with 0x0100
    req_log.delete();
    fetch("redirect 0300", 16'h0100, 26, 5, 16'h0300);
    chk("redirect req count", req_log.size(), 16);
    for (int i = 0; i < 16 && i < req_log.size(); i++)
      chk($sformatf("redirect mem_addr%0d", i), req_log[i],
          (i < 8) ? 16'h0100 + 16'(2 * i) : 16'h0300 + 16'(2 * (i - 8)));
    chk_cnt("redirect", 6, 5);
    fetch("evicted 0100", 16'h0100, 13);
    fetch("hit 0102", 16'h0102, 0);
    chk_cnt("after redirect", 8, 6);

    // 5 reset in stall cycle 6 of a miss on 0x0080
    fetch_req  = 1'b1;
    fetch_addr = 16'h0080;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c < 6) begin
        @(posedge clk); #1;
      end
    end
    chk("pre-reset stall", stall, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("midrst stall", stall, 1'b0);
    chk("midrst mem_rd_req", mem_rd_req, 1'b0);
    chk_cnt("midrst", 0, 0);
    @(posedge clk); #1;
    fetch("after rst 0080", 16'h0080, 13);
    fetch("after rst 0040", 16'h0040, 13);
    chk_cnt("after rst", 2, 2);

    // 6 idle noise: stray return strobe with fetch_req low
    noise = 1'b1;
    @(negedge clk);
    chk("noise stall", stall, 1'b0);
    chk("noise inst_valid", inst_valid, 1'b0);
    @(posedge clk); #1;
    noise = 1'b0;
    @(negedge clk);
    chk_cnt("noise", 2, 2);
    @(posedge clk); #1;
    fetch("noise 0040", 16'h0040, 0);
    fetch("noise 004E", 16'h004E, 0);
    fetch("noise 0080", 16'h0080, 0);
    chk_cnt("final", 5, 2);

    chk("scoreboard drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
